// File: rtl/viterbi_acs_array_if.sv
// Handshake bundle between the branch-metric source, the ACS array and the traceback sink.
// master = upstream/downstream environment, slave = ACS array.
interface viterbi_acs_array_if #(
  parameter int unsigned K    = 3,
  parameter int unsigned BM_W = 2,
  parameter int unsigned PM_W = 8
);
  localparam int unsigned S = 2 ** (K - 1);

  logic                in_valid;
  logic                in_ready;
  logic                start;
  logic [4*BM_W-1:0]   bm;
  logic                out_valid;
  logic                out_ready;
  logic [S-1:0]        decision;
  logic [S-1:0]        state_valid;
  logic [K-2:0]        best_state;
  logic [PM_W-1:0]     best_metric;

  modport master (
    output in_valid, start, bm, out_ready,
    input  in_ready, out_valid, decision, state_valid, best_state, best_metric
  );

  modport slave (
    input  in_valid, start, bm, out_ready,
    output in_ready, out_valid, decision, state_valid, best_state, best_metric
  );
endinterface

// File: rtl/viterbi_acs_array.sv
// Registered add-compare-select array: one full rate-1/2 trellis step per accepted input.
// Optional metric normalisation is enabled by defining ACS_NORM_EN.
module viterbi_acs_array #(
  parameter int unsigned K    = 3,
  parameter int unsigned G0   = 7,
  parameter int unsigned G1   = 5,
  parameter int unsigned BM_W = 2,
  parameter int unsigned PM_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  viterbi_acs_array_if.slave bus
);
  localparam int unsigned     S       = 2 ** (K - 1);
  localparam logic [K-1:0]    G0M     = K'(G0);
  localparam logic [K-1:0]    G1M     = K'(G1);
  localparam logic [PM_W-1:0] PmMax   = '1;
  localparam logic [PM_W-1:0] NormOff = {1'b1, {(PM_W - 1){1'b0}}};

  logic [PM_W-1:0] pm_q [S];
  logic [PM_W-1:0] pm_d [S];
  logic [S-1:0]    pv_q, pv_d;
  logic            out_valid_q, out_valid_d;
  logic [S-1:0]    decision_q, decision_d;
  logic [S-1:0]    state_valid_q, state_valid_d;
  logic [K-2:0]    best_state_q, best_state_d;
  logic [PM_W-1:0] best_metric_q, best_metric_d;

  logic [BM_W-1:0] bm_s [4];
  logic [PM_W-1:0] src_pm [S];
  logic [S-1:0]    src_pv;
  logic [PM_W-1:0] acs_pm [S];
  logic [PM_W-1:0] new_pm [S];
  logic [S-1:0]    acs_v;
  logic [S-1:0]    acs_dec;
  logic [PM_W-1:0] min_pm;
  logic [K-2:0]    min_idx;
  logic            found;
  logic            accept;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      bm_s[j] = bus.bm[j*BM_W +: BM_W];
    end
  end

  // A start step runs from the reset metrics instead of the stored ones.
  always_comb begin
    src_pm = pm_q;
    src_pv = pv_q;
    if (bus.start) begin
      for (int n = 0; n < S; n++) begin
        src_pm[n] = '0;
      end
      src_pv    = '0;
      src_pv[0] = 1'b1;
    end
  end

  // Predecessor px of ns has shift register contents {ns, x}.
  for (genvar n = 0; n < S; n++) begin : g_acs
    localparam int unsigned  P0  = (2 * n) % S;
    localparam int unsigned  P1  = P0 + 1;
    localparam logic [K-1:0] R0  = K'(2 * n);
    localparam logic [K-1:0] R1  = K'(2 * n + 1);
    localparam logic [1:0]   Cw0 = {^(R0 & G0M), ^(R0 & G1M)};
    localparam logic [1:0]   Cw1 = {^(R1 & G0M), ^(R1 & G1M)};

    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] cost0, cost1;
    logic            sel1;

    assign sum0  = {1'b0, src_pm[P0]} + {{(PM_W + 1 - BM_W){1'b0}}, bm_s[Cw0]};
    assign sum1  = {1'b0, src_pm[P1]} + {{(PM_W + 1 - BM_W){1'b0}}, bm_s[Cw1]};
    assign cost0 = sum0[PM_W] ? PmMax : sum0[PM_W-1:0];
    assign cost1 = sum1[PM_W] ? PmMax : sum1[PM_W-1:0];

    // Ties and the both-invalid case fall to path0.
    assign sel1       = src_pv[P1] && (!src_pv[P0] || (cost0 > cost1));
    assign acs_dec[n] = sel1;
    assign acs_v[n]   = src_pv[P0] || src_pv[P1];
    assign acs_pm[n]  = !acs_v[n] ? '0 : (sel1 ? cost1 : cost0);
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_pm  = PmMax;
    min_idx = '0;
    found   = 1'b0;
    for (int n = 0; n < S; n++) begin
      if (acs_v[n] && (!found || (acs_pm[n] < min_pm))) begin
        found   = 1'b1;
        min_pm  = acs_pm[n];
        min_idx = (K - 1)'(n);
      end
    end
  end

  always_comb begin
    new_pm        = acs_pm;
    best_metric_d = min_pm;
`ifdef ACS_NORM_EN
    // Every valid metric is >= min_pm here, so the subtraction cannot underflow.
    if (min_pm >= NormOff) begin
      for (int n = 0; n < S; n++) begin
        if (acs_v[n]) begin
          new_pm[n] = acs_pm[n] - NormOff;
        end
      end
      best_metric_d = min_pm - NormOff;
    end
`endif
  end

  always_comb begin
    pm_d          = pm_q;
    pv_d          = pv_q;
    decision_d    = decision_q;
    state_valid_d = state_valid_q;
    best_state_d  = best_state_q;
    out_valid_d   = out_valid_q;
    if (accept) begin
      pm_d          = new_pm;
      pv_d          = acs_v;
      decision_d    = acs_dec;
      state_valid_d = acs_v;
      best_state_d  = min_idx;
      out_valid_d   = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  logic [PM_W-1:0] best_metric_q_d;
  assign best_metric_q_d = accept ? best_metric_d : best_metric_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < S; n++) begin
        pm_q[n] <= '0;
      end
      pv_q          <= {{(S - 1){1'b0}}, 1'b1};
      out_valid_q   <= 1'b0;
      decision_q    <= '0;
      state_valid_q <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
    end else begin
      pm_q          <= pm_d;
      pv_q          <= pv_d;
      out_valid_q   <= out_valid_d;
      decision_q    <= decision_d;
      state_valid_q <= state_valid_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_q_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.decision    = decision_q;
  assign bus.state_valid = state_valid_q;
  assign bus.best_state  = best_state_q;
  assign bus.best_metric = best_metric_q;

endmodule
